magnitude_stream: RTL and testbench
===================================

// Module: magnitude_stream
// PURPOSE
//  Parametrised, pipelined successor to the combinational 2's-complement magnitude unit.
//  Converts a stream of signed IN_W-bit samples to unsigned (IN_W-1)-bit magnitudes.
//  Uses a valid/ready handshake and a registered output stage.
//  Saturates the most-negative input instead of wrapping, and counts saturation events.
//  Sits between the AHB-Lite slave sample buffer and downstream compare/threshold logic.
// PARAMETERS
//  IN_W   17  input sample width, 2's complement; output width is IN_W-1 (>=3)
//  CNT_W  8   width of saturation event counter (>=2)
// PORTS
//  clk        in   1        system clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        in_data valid this cycle
//  in_ready   out  1        block can accept in_data this cycle
//  in_data    in   IN_W     signed sample
//  out_valid  out  1        out_data/out_sat valid
//  out_ready  in   1        downstream accepts output this cycle
//  out_data   out  IN_W-1   unsigned magnitude
//  out_sat    out  1        this output was saturated
//  clear      in   1        synchronous clear of sat_count (and peak)
//  sat_count  out  CNT_W    number of saturated samples accepted since reset/clear
//  peak       out  IN_W-1   largest magnitude accepted since reset/clear (MAG_PEAK_EN only)
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0; out_valid=0, sat_count=0, peak=0, out_data=0.
//  - in_ready = !out_valid || out_ready (combinational). in_ready may be 1 during reset.
//    No input is accepted while rst=1.
//  - Accept: a transfer occurs when in_valid && in_ready at a rising clk edge.
//  - Latency: exactly 1 cycle. An accepted sample appears on out_data the next cycle,
//    with out_valid=1.
//  - Throughput: 1 sample/cycle while out_ready=1.
//  - Output hold: when out_valid && !out_ready, out_data, out_sat and out_valid hold stable.
//  - Output retire: out_valid drops to 0 after out_ready && out_valid, unless a new sample
//    is accepted in the same edge.
//  - Arithmetic, with s = in_data:
//      s[IN_W-1]=0 -> mag = s[IN_W-2:0], sat=0.
//      s negative and s != 1<<(IN_W-1) -> mag = (~s + 1) truncated to IN_W-1 bits, sat=0.
//      s == 1<<(IN_W-1) (most negative) -> mag = all ones (2^(IN_W-1)-1), sat=1.
//  - sat_count increments by 1 on every accepted sample with sat=1.
//    It sticks at 2^CNT_W-1 and never wraps.
//  - clear=1 sets sat_count (and peak) to 0 at the next edge.
//    Clear takes priority: a sample accepted in the same cycle passes through the datapath
//    normally but does not update sat_count or peak.
//  - Block has no FSM beyond the output-valid flag. States: EMPTY (out_valid=0) and
//    FULL (out_valid=1).
//      EMPTY -> FULL on accept.
//      FULL -> FULL on accept, or on a stall (!out_ready).
//      FULL -> EMPTY on out_ready with no accept.
//  - Mid-operation reset discards any held output immediately; no partial transfer survives.
// CONFIGURATION
//  MAG_PEAK_EN defined:
//   - peak register updates on accept: peak <= max(peak, mag).
//   - A saturated sample sets peak to all ones.
//   - Cleared by rst and by clear.
//  MAG_PEAK_EN undefined:
//   - peak port remains, tied to 0.
//   - No peak register is synthesised.
// TESTING
//  (IN_W=17, CNT_W=4 unless stated)
//  1. in_data=0x1FFFF (-1), out_ready=1 -> next cycle out_data=0x0001, out_sat=0, out_valid=1.
//  2. in_data=0x10000 (-65536) -> out_data=0xFFFF, out_sat=1, sat_count 0->1.
//     in_data=0x0FFFF -> out_data=0xFFFF, out_sat=0.
//  3. Backpressure: stream 5,-7,9 with out_ready=0 for 3 cycles after first accept.
//     -> in_ready=0, out_data holds 5.
//     -> After release, outputs 5,7,9 in order; no loss, no duplication.
//  4. 20 consecutive saturating samples -> sat_count stops at 15.
//     clear=1 concurrent with a saturating accept -> sat_count=0 next cycle; out_sat=1 still delivered.
//  5. MAG_PEAK_EN: inputs 3,-100,50 -> peak=100; clear -> peak=0.
//     Without the macro, peak stays 0 throughout.
//  6. Assert rst asynchronously while out_valid=1 and out_ready=0.
//     -> out_valid=0, sat_count=0 immediately.
//     -> The first post-reset sample has 1-cycle latency.

Source files
------------

// File: rtl/magnitude_stream.sv
// magnitude_stream: signed IN_W-bit samples -> unsigned (IN_W-1)-bit magnitudes, saturating the most-negative code.
// Latency: 1 cycle (registered output stage), 1 sample/cycle throughput while out_ready=1.
// Backpressure: in_ready = !out_valid || out_ready; held output stays stable while stalled. Optional peak tracker: MAG_PEAK_EN.
module magnitude_stream #(
    parameter int IN_W  = 17,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IN_W-2:0]   out_data,
    output logic              out_sat,
    input  logic              clear,
    output logic [CNT_W-1:0]  sat_count,
    output logic [IN_W-2:0]   peak
);

    // The only state is whether the output register holds an undelivered sample.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [IN_W-1:0]  MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-2:0]  MAG_MAX  = {(IN_W-1){1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IN_W-2:0]    r_data;
    logic               r_sat;
    logic [CNT_W-1:0]   r_sat_count;

    logic               w_accept;
    logic               w_neg;
    logic               w_most_neg;
    logic [IN_W-1:0]    w_twos;
    logic [IN_W-2:0]    w_mag;
    logic               w_sat;

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    // rst holds every flop, so a handshake seen during reset is never captured.
    assign w_accept  = in_valid && in_ready;

    // Magnitude of the incoming sample; the most-negative code has no positive twin and saturates.
    always_comb begin
        w_neg      = in_data[IN_W-1];
        w_most_neg = (in_data == MOST_NEG);
        w_twos     = ~in_data + {{(IN_W-1){1'b0}}, 1'b1};
        w_sat      = w_most_neg;
        if (w_most_neg) begin
            w_mag = MAG_MAX;
        end else if (w_neg) begin
            w_mag = w_twos[IN_W-2:0];
        end else begin
            w_mag = in_data[IN_W-2:0];
        end
    end

    // Output-valid state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: fill on accept, hold while stalled, drain when consumed without a refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output payload register; only loads on accept so a stalled output stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_sat  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_mag;
            r_sat  <= w_sat;
        end
    end

    assign out_data = r_data;
    assign out_sat  = r_sat;

    // Saturation event counter: clear wins over a same-cycle increment, sticks at its maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (clear) begin
            r_sat_count <= '0;
        end else if (w_accept && w_sat && (r_sat_count != CNT_MAX)) begin
            r_sat_count <= r_sat_count + CNT_ONE;
        end
    end

    assign sat_count = r_sat_count;

`ifdef MAG_PEAK_EN
    logic [IN_W-2:0] r_peak;

    // Running maximum of accepted magnitudes; a saturated sample is already all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak <= '0;
        end else if (clear) begin
            r_peak <= '0;
        end else if (w_accept && (w_mag > r_peak)) begin
            r_peak <= w_mag;
        end
    end

    assign peak = r_peak;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_magnitude_stream.sv
// Directed bench for magnitude_stream with IN_W=17, CNT_W=4.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
module tb_magnitude_stream;

    localparam int IN_W  = 17;
    localparam int CNT_W = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [IN_W-2:0]   out_data;
    logic              out_sat;
    logic              clear;
    logic [CNT_W-1:0]  sat_count;
    logic [IN_W-2:0]   peak;

    int n_chk;
    int n_bad;

    magnitude_stream #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .clear     (clear),
        .sat_count (sat_count),
        .peak      (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_peak(input string tag, input logic [IN_W-2:0] exp_en);
`ifdef MAG_PEAK_EN
        chk(tag, 32'(peak), 32'(exp_en));
`else
        chk(tag, 32'(peak), 32'h0);
`endif
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clear     = 1'b0;
        step();
        step();

        // reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_sat",   32'(out_sat),   32'h0);
        chk("rst_sat_count", 32'(sat_count), 32'h0);
        chk_peak("rst_peak", 16'h0000);
        rst = 1'b0;
        step();

        // -1 -> 1
        in_valid = 1'b1; in_data = 17'h1FFFF;
        step();
        chk("neg1_valid", 32'(out_valid), 32'h1);
        chk("neg1_data",  32'(out_data),  32'h0001);
        chk("neg1_sat",   32'(out_sat),   32'h0);

        // most negative saturates, largest positive does not
        in_data = 17'h10000;
        step();
        chk("mostneg_data", 32'(out_data),  32'hFFFF);
        chk("mostneg_sat",  32'(out_sat),   32'h1);
        chk("mostneg_cnt",  32'(sat_count), 32'h1);
        in_data = 17'h0FFFF;
        step();
        chk("maxpos_data", 32'(out_data),  32'hFFFF);
        chk("maxpos_sat",  32'(out_sat),   32'h0);
        chk("maxpos_cnt",  32'(sat_count), 32'h1);
        in_valid = 1'b0;
        step();
        chk("retire_valid", 32'(out_valid), 32'h0);

        // backpressure: 5, -7, 9 with a 3-cycle stall after the first accept
        in_valid = 1'b1; in_data = 17'd5;
        step();
        chk("bp_first_data", 32'(out_data), 32'd5);
        out_ready = 1'b0; in_data = 17'h1FFF9;
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data",  32'(out_data),  32'd5);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_second_data", 32'(out_data), 32'd7);
        in_data = 17'd9;
        step();
        chk("bp_third_data", 32'(out_data), 32'd9);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", 32'(out_valid), 32'h0);

        // counter saturation: 1 already + 20 more sticks at 15
        in_valid = 1'b1; in_data = 17'h10000;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) chk("cnt_mid", 32'(sat_count), 32'd7);
        end
        chk("cnt_stick", 32'(sat_count), 32'd15);
        clear = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_cnt",     32'(sat_count), 32'h0);
        chk("clr_out_sat", 32'(out_sat),   32'h1);
        chk("clr_out_dat", 32'(out_data),  32'hFFFF);
        chk_peak("clr_peak", 16'h0000);
        step();
        chk("clr_cnt_hold", 32'(sat_count), 32'h0);

        // peak tracking: 3, -100, 50 -> 100
        in_valid = 1'b1; in_data = 17'd3;
        step();
        chk("pk_d3", 32'(out_data), 32'd3);
        in_data = 17'h1FF9C;
        step();
        chk("pk_d100", 32'(out_data), 32'd100);
        in_data = 17'd50;
        step();
        chk("pk_d50", 32'(out_data), 32'd50);
        in_valid = 1'b0;
        step();
        chk_peak("pk_max", 16'd100);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_peak("pk_clear", 16'h0000);

        // async reset while stalled
        in_valid = 1'b1; in_data = 17'h10000;
        step();
        chk("ar_cnt_pre", 32'(sat_count), 32'h1);
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("ar_stall_valid", 32'(out_valid), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_cnt",   32'(sat_count), 32'h0);
        chk("ar_data",  32'(out_data),  32'h0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 17'h10000;
        step();
        chk("ar_no_accept", 32'(out_valid), 32'h0);
        chk("ar_no_count",  32'(sat_count), 32'h0);
        rst = 1'b0; in_data = 17'h0002A;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_data",  32'(out_data),  32'h002A);
        in_valid = 1'b0;
        step();
        chk("post_rst_drain", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
